boson_capture_ctrl: RTL and testbench



---
 rtl/boson_capture_ctrl.sv | 136 +++++++++++++
 tb/tb_boson_capture_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/boson_capture_ctrl.sv
// Frame-capture sequencer: arms on request, syncs to VSYNC rising edge,
// streams frames_req frames of pixels into a linear buffer through a
// one-entry output register, and flags short frames and dropped pixels.
module boson_capture_ctrl #(
  parameter int DATA_W   = 16,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 512,
  parameter int ADDR_W   = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arm,
  input  logic              abort,
  input  logic [7:0]        frames_req,
  input  logic              cam_vsync,
  input  logic              cam_valid,
  input  logic [DATA_W-1:0] cam_data,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic              wr_ready,
  output logic              busy,
  output logic              done,
  output logic [7:0]        frames_done,
  output logic              err_overflow,
  output logic              err_size
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

  typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE, DRAIN} state_t;

  state_t            state, state_nx;
  logic              vs_q;
  logic              vs_rise, hs;
  logic [ADDR_W-1:0] pix_cnt, pix_idx;
  logic [7:0]        eff_req;
  logic              accept, start, restart, take, load, drop, frame_end, fin;

  assign vs_rise = cam_vsync & ~vs_q;
  assign hs      = wr_valid & wr_ready;
  assign busy    = (state != IDLE);

  // Next state and per-cycle strobes; abort in an active state overrides everything.
  always_comb begin
    state_nx  = state;
    accept    = 1'b0;
    start     = 1'b0;
    restart   = 1'b0;
    fin       = 1'b0;
    frame_end = 1'b0;
    pix_idx   = pix_cnt;
    case (state)
      IDLE:    if (arm && !abort) begin state_nx = WAIT_VS; accept = 1'b1; end
      WAIT_VS: if (vs_rise) begin state_nx = CAPTURE; start = 1'b1; end
      CAPTURE: if (vs_rise) restart = 1'b1;
      DRAIN:   if (!wr_valid || wr_ready) begin state_nx = IDLE; fin = 1'b1; end
      default: state_nx = IDLE;
    endcase
    // The VSYNC-rise cycle is itself pixel 0 of the (re)started frame.
    if (start || restart) pix_idx = '0;
    take = cam_valid && (start || state == CAPTURE);
    if (take && pix_idx == LAST) begin
      frame_end = 1'b1;
      state_nx  = ((frames_done + 8'd1) == eff_req) ? DRAIN : WAIT_VS;
    end
    if (abort && state != IDLE) begin
      state_nx  = IDLE;
      fin       = 1'b0;
      take      = 1'b0;
      restart   = 1'b0;
      start     = 1'b0;
      frame_end = 1'b0;
    end
    // A slot freed by a handshake this cycle can take the new pixel.
    load = take && (!wr_valid || wr_ready);
    drop = take && wr_valid && !wr_ready;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // VSYNC history, tracked in every state so edges are never missed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) vs_q <= 1'b0;
    else       vs_q <= cam_vsync;
  end

  // Pixel counter, frame count and sticky error flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_cnt      <= '0;
      frames_done  <= '0;
      eff_req      <= '0;
      err_overflow <= 1'b0;
      err_size     <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= fin;
      if (accept) begin
        pix_cnt      <= '0;
        frames_done  <= '0;
        err_overflow <= 1'b0;
        err_size     <= 1'b0;
        eff_req      <= (frames_req == 8'd0) ? 8'd1 : frames_req;
      end
      if (restart) err_size <= 1'b1;
      if (drop)    err_overflow <= 1'b1;
      // Dropped pixels still advance the counter so later addresses never slip.
      if (take)                  pix_cnt <= frame_end ? '0 : pix_idx + ADDR_W'(1);
      else if (start || restart) pix_cnt <= '0;
      if (frame_end) frames_done <= frames_done + 8'd1;
    end
  end

  // One-entry write register; held stable until the buffer takes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else if (abort && state != IDLE) begin
      wr_valid <= 1'b0;
    end else if (load) begin
      wr_valid <= 1'b1;
      wr_addr  <= pix_idx;
      wr_data  <= cam_data;
    end else if (hs) begin
      wr_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_boson_capture_ctrl.sv
// Bench for boson_capture_ctrl on a 4x2 frame: directed scenarios then
// randomized traffic, every cycle compared against a transaction-level model.
module tb_boson_capture_ctrl;

  localparam int DW = 16;
  localparam int AW = 19;
  localparam int TOTAL = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          arm, abort, cam_vsync, cam_valid, wr_ready;
  logic [7:0]    frames_req;
  logic [DW-1:0] cam_data;
  logic          wr_valid, busy, done, err_overflow, err_size;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [7:0]    frames_done;

  int n_chk = 0;
  int n_fail = 0;

  // reference model state
  int            m_phase;  // 0 idle, 1 waiting for vsync, 2 capturing, 3 draining
  int            m_pix, m_frames, m_eff;
  bit            m_eovf, m_esize, m_done, m_vsq, m_slot_v;
  logic [AW-1:0] m_slot_a;
  logic [DW-1:0] m_slot_d;

  boson_capture_ctrl #(.DATA_W(DW), .H_ACTIVE(4), .V_ACTIVE(2), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .arm(arm), .abort(abort), .frames_req(frames_req),
    .cam_vsync(cam_vsync), .cam_valid(cam_valid), .cam_data(cam_data),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .busy(busy), .done(done), .frames_done(frames_done),
    .err_overflow(err_overflow), .err_size(err_size)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_phase = 0; m_pix = 0; m_frames = 0; m_eff = 1;
    m_eovf = 0; m_esize = 0; m_done = 0; m_vsq = 0; m_slot_v = 0;
    m_slot_a = '0; m_slot_d = '0;
  endtask

  // Advance the model one clock using the inputs currently driven.
  task automatic m_step();
    bit vr, occ, hs, cap, loaded;
    vr = cam_vsync && !m_vsq;
    occ = m_slot_v;
    hs = occ && wr_ready;
    cap = 0; loaded = 0;
    m_vsq = cam_vsync;
    m_done = 0;
    if (m_phase != 0 && abort) begin
      m_phase = 0;
      m_slot_v = 0;
    end else begin
      case (m_phase)
        0: if (arm && !abort) begin
             m_phase = 1; m_frames = 0; m_eovf = 0; m_esize = 0; m_pix = 0;
             m_eff = (frames_req == 0) ? 1 : int'(frames_req);
           end
        1: if (vr) begin m_phase = 2; m_pix = 0; cap = 1; end
        2: begin
             cap = 1;
             if (vr) begin m_esize = 1; m_pix = 0; end
           end
        default: if (!occ || hs) begin m_done = 1; m_phase = 0; end
      endcase
      if (cap && cam_valid) begin
        if (occ && !wr_ready) m_eovf = 1;
        else begin loaded = 1; m_slot_a = AW'(m_pix); m_slot_d = cam_data; end
        m_pix++;
        if (m_pix == TOTAL) begin
          m_frames++;
          m_pix = 0;
          m_phase = (m_frames == m_eff) ? 3 : 1;
        end
      end
      if (loaded) m_slot_v = 1;
      else if (hs) m_slot_v = 0;
    end
  endtask

  // One clock: drive inputs, compare mid-cycle, step model, move to next cycle.
  task automatic cyc(input logic a, input logic ab, input logic vs, input logic v,
                     input logic [DW-1:0] d, input logic rdy);
    arm = a; abort = ab; cam_vsync = vs; cam_valid = v; cam_data = d; wr_ready = rdy;
    #3;
    chk("busy", busy, m_phase != 0);
    chk("done", done, m_done);
    chk("frames_done", frames_done, m_frames[7:0]);
    chk("err_overflow", err_overflow, m_eovf);
    chk("err_size", err_size, m_esize);
    chk("wr_valid", wr_valid, m_slot_v);
    if (m_slot_v) begin
      chk("wr_addr", wr_addr, m_slot_a);
      chk("wr_data", wr_data, m_slot_d);
    end
    m_step();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, '0, 1);
  endtask

  // VSYNC pulse with no pixel, then n pixels at base+i, wr_ready held high.
  task automatic frame(input int n, input logic [DW-1:0] base);
    cyc(0, 0, 1, 0, '0, 1);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 1, base + DW'(i), 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    arm = 0; abort = 0; cam_vsync = 0; cam_valid = 0; wr_ready = 0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_frames_done", frames_done, 0);
    chk("rst_err", {err_overflow, err_size}, 0);
    chk("rst_wr_addr", wr_addr, 0);
    m_reset();
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    bit vs_r;
    reset = 1'b1; arm = 0; abort = 0; cam_vsync = 0; cam_valid = 0;
    cam_data = '0; wr_ready = 1; frames_req = 8'd1;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // single frame, wr_ready always high
    frames_req = 8'd1;
    cyc(1, 0, 0, 0, '0, 1);
    idle(2);
    frame(8, 16'h0100);
    idle(3);
    chk("t1_frames", frames_done, 1);
    chk("t1_busy", busy, 0);

    // three frames back to back, one done pulse
    frames_req = 8'd3;
    cyc(1, 0, 0, 0, '0, 1);
    frame(8, 16'h0200);
    frame(8, 16'h0300);
    frame(8, 16'h0400);
    idle(3);
    chk("t2_frames", frames_done, 3);

    // short frame after 5 pixels, then a full one
    frames_req = 8'd1;
    cyc(1, 0, 0, 0, '0, 1);
    frame(5, 16'h0500);
    frame(8, 16'h0600);
    idle(3);
    chk("t3_err_size", err_size, 1);
    chk("t3_frames", frames_done, 1);

    // backpressure: wr_ready low for 3 cycles during a continuous stream
    cyc(1, 0, 0, 0, '0, 1);
    cyc(0, 0, 1, 1, 16'h0700, 1);
    cyc(0, 0, 0, 1, 16'h0701, 0);
    cyc(0, 0, 0, 1, 16'h0702, 0);
    cyc(0, 0, 0, 1, 16'h0703, 0);
    for (int i = 4; i < 8; i++) cyc(0, 0, 0, 1, 16'h0700 + DW'(i), 1);
    idle(3);
    chk("t4_err_overflow", err_overflow, 1);

    // abort mid-frame, then a clean capture
    cyc(1, 0, 0, 0, '0, 1);
    frame(3, 16'h0800);
    cyc(0, 1, 0, 0, '0, 0);
    cyc(0, 0, 0, 0, '0, 0);
    chk("t5_busy", busy, 0);
    cyc(1, 0, 0, 0, '0, 1);
    frame(8, 16'h0900);
    idle(3);

    // frames_req == 0 means one frame; arm with abort in idle stays idle
    frames_req = 8'd0;
    cyc(1, 0, 0, 0, '0, 1);
    frame(8, 16'h0a00);
    idle(3);
    chk("t6_frames", frames_done, 1);
    cyc(1, 1, 0, 0, '0, 1);
    idle(2);

    // randomized traffic; mid-capture resets now and then
    vs_r = 0;
    for (int i = 0; i < 4000; i++) begin
      if (m_phase == 0) frames_req = 8'($urandom_range(0, 3));
      if ($urandom_range(0, 599) == 0) do_reset();
      vs_r = ($urandom_range(0, 11) == 0) || (vs_r && $urandom_range(0, 1) == 1);
      cyc($urandom_range(0, 19) == 0, $urandom_range(0, 149) == 0, vs_r,
          $urandom_range(0, 9) < 7, DW'($urandom), $urandom_range(0, 9) < 8);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
